// File: rtl/core_bus_arbiter_pkg.sv
// Shared definitions for the core bus arbiter: FSM states and master indices.
package core_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      RDATA = 3'd2,
      WDATA = 3'd3,
      WRESP = 3'd4
   } arb_state_e;

   // Port 0 is instruction fetch, port 1 is the data cache / LSU.
   localparam logic MST_I = 1'b0;
   localparam logic MST_D = 1'b1;

   // One-hot per-master strobe for a granted index.
   function automatic logic [1:0] mst_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Signal bundle between the two cache controllers, the arbiter and the AXI bridge.
// Handshake rule for every valid/ready pair: a transfer happens on a rising clk
// edge where both are high; a raised valid holds with a stable payload until that
// edge; ready may depend combinationally on valid.
interface core_bus_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);
   // requester side (0 = I-fetch, 1 = D-cache/LSU)
   logic [1:0]                   m_req_valid_i;
   logic [1:0]                   m_req_ready_o;
   logic [1:0]                   m_req_write_i;
   logic [1:0][31:0]             m_req_addr_i;
   logic [1:0][LEN_WIDTH-1:0]    m_req_len_i;
   logic [1:0][1:0]              m_req_size_i;
   logic [1:0]                   m_wvalid_i;
   logic [1:0]                   m_wready_o;
   logic [1:0][DATA_WIDTH-1:0]   m_wdata_i;
   logic [1:0][DATA_WIDTH/8-1:0] m_wstrb_i;
   logic [1:0]                   m_wlast_i;
   logic [1:0]                   m_rvalid_o;
   logic [DATA_WIDTH-1:0]        m_rdata_o;
   logic                         m_rlast_o;
   logic [1:0]                   m_bvalid_o;
   logic                         flush_i;
   // bridge side
   logic                         bus_req_valid_o;
   logic                         bus_req_ready_i;
   logic                         bus_req_write_o;
   logic [31:0]                  bus_req_addr_o;
   logic [LEN_WIDTH-1:0]         bus_req_len_o;
   logic [1:0]                   bus_req_size_o;
   logic                         bus_wvalid_o;
   logic                         bus_wready_i;
   logic [DATA_WIDTH-1:0]        bus_wdata_o;
   logic [DATA_WIDTH/8-1:0]      bus_wstrb_o;
   logic                         bus_wlast_o;
   logic                         bus_rvalid_i;
   logic [DATA_WIDTH-1:0]        bus_rdata_i;
   logic                         bus_rlast_i;
   logic                         bus_bvalid_i;
   logic                         bus_busy_o;

   // arbiter view
   modport slave (
      input  m_req_valid_i, m_req_write_i, m_req_addr_i, m_req_len_i, m_req_size_i,
             m_wvalid_i, m_wdata_i, m_wstrb_i, m_wlast_i, flush_i,
             bus_req_ready_i, bus_wready_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i,
             bus_bvalid_i,
      output m_req_ready_o, m_wready_o, m_rvalid_o, m_rdata_o, m_rlast_o, m_bvalid_o,
             bus_req_valid_o, bus_req_write_o, bus_req_addr_o, bus_req_len_o,
             bus_req_size_o, bus_wvalid_o, bus_wdata_o, bus_wstrb_o, bus_wlast_o,
             bus_busy_o
   );

   // environment view (requesters plus bridge)
   modport master (
      output m_req_valid_i, m_req_write_i, m_req_addr_i, m_req_len_i, m_req_size_i,
             m_wvalid_i, m_wdata_i, m_wstrb_i, m_wlast_i, flush_i,
             bus_req_ready_i, bus_wready_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i,
             bus_bvalid_i,
      input  m_req_ready_o, m_wready_o, m_rvalid_o, m_rdata_o, m_rlast_o, m_bvalid_o,
             bus_req_valid_o, bus_req_write_o, bus_req_addr_o, bus_req_len_o,
             bus_req_size_o, bus_wvalid_o, bus_wdata_o, bus_wstrb_o, bus_wlast_o,
             bus_busy_o
   );
endinterface

// File: rtl/core_bus_arb_pick.sv
// Two-way priority select: D-side wins unless I-side has been starved too long.
module core_bus_arb_pick
   import core_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       starve,
   output logic       idx,
   output logic       valid
);

   // D beats I, except when the starvation limit is reached and I is waiting
   always_comb begin
      valid = |req;
      idx   = MST_D;
      if (!req[MST_D] || (starve && req[MST_I])) idx = MST_I;
   end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares the core-side cache bus between I-fetch (port 0) and D-cache (port 1).
// Grant is held for a whole burst; write data is passed straight through, read
// beats are steered to the winner, and I-side reads can be silently drained
// after a frontend redirect.
module core_bus_arbiter
   import core_bus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int LEN_WIDTH    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   core_bus_arbiter_if.slave   io,
   output arb_state_e          dbg_state_o
);

   localparam int            CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   arb_state_e             state;
   logic                   grant;
   logic [CW-1:0]          starve_cnt;
   logic                   drop;
   logic                   wr_q;
   logic [1:0]             bvalid_q;
   logic [31:0]            addr_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [1:0]             size_q;

   logic                   pick_idx;
   logic                   pick_valid;
   logic                   read_flush;
   logic                   w_valid;
   logic [1:0]             r_valid;
   logic [DATA_WIDTH-1:0]  wdata_sel;
   logic [DATA_WIDTH/8-1:0] wstrb_sel;

   core_bus_arb_pick u_pick (
      .req    (io.m_req_valid_i),
      .starve (starve_cnt == LIMIT),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   // A redirect while the I-side owns a read turns the rest of it into a drain
   assign read_flush = io.flush_i && (grant == MST_I) && !wr_q;

   // Control FSM: grant, starvation counter, drain flag and completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= MST_I;
         starve_cnt <= '0;
         drop       <= 1'b0;
         wr_q       <= 1'b0;
         bvalid_q   <= '0;
      end else begin
         bvalid_q <= '0;
         case (state)
            IDLE: begin
               drop <= pick_valid && (pick_idx == MST_I) &&
                       !io.m_req_write_i[MST_I] && io.flush_i;
               if (pick_valid) begin
                  grant <= pick_idx;
                  wr_q  <= io.m_req_write_i[pick_idx];
                  state <= ADDR;
                  if (pick_idx == MST_I)
                     starve_cnt <= '0;
                  else if (io.m_req_valid_i[MST_I] && starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + CW'(1);
               end
            end
            ADDR: begin
               if (read_flush) drop <= 1'b1;
               if (io.bus_req_ready_i) state <= wr_q ? WDATA : RDATA;
            end
            RDATA: begin
               if (read_flush) drop <= 1'b1;
               if (io.bus_rvalid_i && io.bus_rlast_i) begin
                  state <= IDLE;
                  drop  <= 1'b0;
               end
            end
            WDATA: begin
               if (w_valid && io.bus_wready_i && io.m_wlast_i[grant]) state <= WRESP;
            end
            WRESP: begin
               if (io.bus_bvalid_i) begin
                  bvalid_q <= mst_onehot(grant);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Capture the winner's request fields at grant time
   always_ff @(posedge clk) begin
      if (state == IDLE && pick_valid) begin
         addr_q <= io.m_req_addr_i[pick_idx];
         len_q  <= io.m_req_len_i[pick_idx];
         size_q <= io.m_req_size_i[pick_idx];
      end
   end

   // Output steering; request ready is also masked while reset is held
   always_comb begin
      w_valid   = (state == WDATA) && io.m_wvalid_i[grant];
      wdata_sel = io.m_wdata_i[grant];
      wstrb_sel = io.m_wstrb_i[grant];
      r_valid   = '0;
      if (state == RDATA && io.bus_rvalid_i && !drop && !read_flush)
         r_valid = mst_onehot(grant);

      io.m_req_ready_o = '0;
      if (rst_n && state == IDLE && pick_valid) io.m_req_ready_o = mst_onehot(pick_idx);

      io.m_wready_o = '0;
      if (state == WDATA && io.bus_wready_i) io.m_wready_o = mst_onehot(grant);

      io.m_rvalid_o      = r_valid;
      io.m_rdata_o       = io.bus_rdata_i;
      io.m_rlast_o       = io.bus_rlast_i && (|r_valid);
      io.m_bvalid_o      = bvalid_q;

      io.bus_req_valid_o = (state == ADDR);
      io.bus_req_write_o = wr_q;
      io.bus_req_addr_o  = addr_q;
      io.bus_req_len_o   = len_q;
      io.bus_req_size_o  = size_q;
      io.bus_wvalid_o    = w_valid;
      io.bus_wdata_o     = wdata_sel;
      io.bus_wstrb_o     = wstrb_sel;
      io.bus_wlast_o     = io.m_wlast_i[grant];
      io.bus_busy_o      = (state != IDLE);
      dbg_state_o        = state;
   end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed-plus-random bench for core_bus_arbiter with a transaction-level model.
module tb_core_bus_arbiter;
   import core_bus_arbiter_pkg::*;

   localparam int STARVE = 4;

   logic       clk;
   logic       rst_n;
   arb_state_e dbg_state;
   int         n_vec;
   int         n_fail;
   logic [31:0] exp_q[$];

   core_bus_arbiter_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) bus_if ();

   core_bus_arbiter #(.STARVE_LIMIT(STARVE), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .io          (bus_if),
      .dbg_state_o (dbg_state)
   );

   // clock and global time bound
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic logic [1:0] oh(input int p);
      return (p == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive point: just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sample point: falling edge
   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus_if.m_req_valid_i   = '0;
      bus_if.m_req_write_i   = '0;
      bus_if.m_req_addr_i    = '0;
      bus_if.m_req_len_i     = '0;
      bus_if.m_req_size_i    = '0;
      bus_if.m_wvalid_i      = '0;
      bus_if.m_wdata_i       = '0;
      bus_if.m_wstrb_i       = '0;
      bus_if.m_wlast_i       = '0;
      bus_if.flush_i         = 1'b0;
      bus_if.bus_req_ready_i = 1'b0;
      bus_if.bus_wready_i    = 1'b0;
      bus_if.bus_rvalid_i    = 1'b0;
      bus_if.bus_rdata_i     = '0;
      bus_if.bus_rlast_i     = 1'b0;
      bus_if.bus_bvalid_i    = 1'b0;
   endtask

   // One complete transaction from a single requester, checked beat by beat.
   // Starts and ends at a drive point with the arbiter idle.
   task automatic run_txn(input int port, input bit wr, input int len,
                          input int flush_beat, input int stall, input bit toggle);
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [1:0]  exp_rv;
      bit          rv, dropped, wr_rdy;
      int          beat, guard, n_fwd, d;
      addr = $urandom;
      size = 2'($urandom_range(0, 2));
      bus_if.m_req_valid_i       = oh(port);
      bus_if.m_req_write_i[port] = wr;
      bus_if.m_req_addr_i[port]  = addr;
      bus_if.m_req_len_i[port]   = 8'(len);
      bus_if.m_req_size_i[port]  = size;
      settle();
      check("req_ready_at_T", 64'(bus_if.m_req_ready_o), 64'(oh(port)));
      check("busy_idle", 64'(bus_if.bus_busy_o), 64'd0);
      tick();
      bus_if.m_req_valid_i = '0;
      // address phase, optionally stalled by the bridge
      for (int s = 0; s <= stall; s++) begin
         bus_if.bus_req_ready_i = (s == stall);
         bus_if.m_req_valid_i   = (s < stall) ? 2'b11 : 2'b00;
         settle();
         check("bus_req_valid", 64'(bus_if.bus_req_valid_o), 64'd1);
         check("bus_req_addr", 64'(bus_if.bus_req_addr_o), 64'(addr));
         check("bus_req_len", 64'(bus_if.bus_req_len_o), 64'(len));
         check("bus_req_size", 64'(bus_if.bus_req_size_o), 64'(size));
         check("bus_req_write", 64'(bus_if.bus_req_write_o), 64'(wr));
         check("no_second_grant", 64'(bus_if.m_req_ready_o), 64'd0);
         tick();
      end
      bus_if.bus_req_ready_i = 1'b0;
      bus_if.m_req_valid_i   = '0;
      if (!wr) begin
         beat = 0; guard = 0; dropped = 0;
         while (beat <= len && guard < 200) begin
            rv = ($urandom_range(0, 3) != 0);
            bus_if.bus_rvalid_i = rv;
            bus_if.bus_rdata_i  = $urandom;
            bus_if.bus_rlast_i  = rv && (beat == len);
            bus_if.flush_i      = rv && (beat == flush_beat);
            settle();
            if (bus_if.flush_i && port == 0) dropped = 1;
            exp_rv = (rv && !dropped) ? oh(port) : 2'b00;
            if (exp_rv != 2'b00) exp_q.push_back(bus_if.bus_rdata_i);
            check("m_rvalid", 64'(bus_if.m_rvalid_o), 64'(exp_rv));
            check("busy_rdata", 64'(bus_if.bus_busy_o), 64'd1);
            if (bus_if.m_rvalid_o[port] && exp_q.size() > 0) begin
               check("m_rdata", 64'(bus_if.m_rdata_o), 64'(exp_q.pop_front()));
               check("m_rlast", 64'(bus_if.m_rlast_o), 64'(beat == len));
            end
            if (rv) beat++;
            tick();
            guard++;
         end
         bus_if.bus_rvalid_i = 1'b0;
         bus_if.bus_rlast_i  = 1'b0;
         bus_if.flush_i      = 1'b0;
         check("rd_leftover", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         settle();
         check("busy_after_rlast", 64'(bus_if.bus_busy_o), 64'd0);
         check("rvalid_after_rlast", 64'(bus_if.m_rvalid_o), 64'd0);
         tick();
      end else begin
         beat = 0; guard = 0; n_fwd = 0;
         wd = $urandom;
         ws = 4'($urandom_range(0, 15));
         while (beat <= len && guard < 200) begin
            bus_if.m_wvalid_i        = oh(port);
            bus_if.m_wdata_i[port]   = wd;
            bus_if.m_wstrb_i[port]   = ws;
            bus_if.m_wlast_i[port]   = (beat == len);
            wr_rdy = toggle ? (guard % 2 == 0) : ($urandom_range(0, 1) == 1);
            bus_if.bus_wready_i = wr_rdy;
            settle();
            check("bus_wvalid", 64'(bus_if.bus_wvalid_o), 64'd1);
            check("bus_wdata", 64'(bus_if.bus_wdata_o), 64'(wd));
            check("bus_wstrb", 64'(bus_if.bus_wstrb_o), 64'(ws));
            check("bus_wlast", 64'(bus_if.bus_wlast_o), 64'(beat == len));
            check("m_wready", 64'(bus_if.m_wready_o), wr_rdy ? 64'(oh(port)) : 64'd0);
            if (bus_if.bus_wvalid_o && wr_rdy) n_fwd++;
            if (wr_rdy) begin
               beat++;
               wd = $urandom;
               ws = 4'($urandom_range(0, 15));
            end
            tick();
            guard++;
         end
         bus_if.m_wvalid_i   = '0;
         bus_if.m_wlast_i    = '0;
         bus_if.bus_wready_i = 1'b0;
         check("w_beats_fwd", 64'(n_fwd), 64'(len + 1));
         d = $urandom_range(0, 3);
         for (int i = 0; i < d; i++) begin
            settle();
            check("bvalid_wait", 64'(bus_if.m_bvalid_o), 64'd0);
            check("busy_wresp", 64'(bus_if.bus_busy_o), 64'd1);
            tick();
         end
         bus_if.bus_bvalid_i = 1'b1;
         settle();
         check("bvalid_not_same_cycle", 64'(bus_if.m_bvalid_o), 64'd0);
         tick();
         bus_if.bus_bvalid_i = 1'b0;
         settle();
         check("bvalid_pulse", 64'(bus_if.m_bvalid_o), 64'(oh(port)));
         check("busy_after_bresp", 64'(bus_if.bus_busy_o), 64'd0);
         tick();
         settle();
         check("bvalid_single", 64'(bus_if.m_bvalid_o), 64'd0);
         tick();
      end
   endtask

   initial begin
      logic [1:0] exp_g;
      int         wait_cnt;
      bit         got;
      int         port, len, fb;
      bit         wr;
      n_vec  = 0;
      n_fail = 0;
      clear_inputs();
      rst_n = 1'b0;

      // reset state, with requests and beats present to make it meaningful
      bus_if.m_req_valid_i = 2'b11;
      bus_if.bus_rvalid_i  = 1'b1;
      bus_if.bus_bvalid_i  = 1'b1;
      #12;
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      check("rst_busy", 64'(bus_if.bus_busy_o), 64'd0);
      check("rst_req_ready", 64'(bus_if.m_req_ready_o), 64'd0);
      check("rst_rvalid", 64'(bus_if.m_rvalid_o), 64'd0);
      check("rst_bvalid", 64'(bus_if.m_bvalid_o), 64'd0);
      check("rst_bus_req_valid", 64'(bus_if.bus_req_valid_o), 64'd0);
      clear_inputs();
      settle();
      rst_n = 1'b1;
      tick();

      // I-side read of 8 beats alone
      run_txn(0, 1'b0, 7, -1, 0, 1'b0);
      // D-side write of 4 beats with the bridge ready toggling
      run_txn(1, 1'b1, 3, -1, 0, 1'b1);
      // I-side read of 4 beats with a redirect on beat 1
      run_txn(0, 1'b0, 3, 1, 0, 1'b0);
      // address phase held off for 10 cycles while both ports request
      run_txn(1, 1'b0, 2, -1, 10, 1'b0);

      // reset in the middle of a read burst
      bus_if.m_req_valid_i    = 2'b01;
      bus_if.m_req_write_i[0] = 1'b0;
      bus_if.m_req_len_i[0]   = 8'd5;
      bus_if.m_req_addr_i[0]  = $urandom;
      settle();
      check("mid_rst_grant", 64'(bus_if.m_req_ready_o), 64'd1);
      tick();
      bus_if.m_req_valid_i   = '0;
      bus_if.bus_req_ready_i = 1'b1;
      tick();
      bus_if.bus_req_ready_i = 1'b0;
      bus_if.bus_rvalid_i    = 1'b1;
      bus_if.bus_rdata_i     = $urandom;
      settle();
      check("mid_rst_beat0", 64'(bus_if.m_rvalid_o), 64'd1);
      tick();
      bus_if.m_req_valid_i = 2'b10;
      #2;
      check("nonwinner_ready", 64'(bus_if.m_req_ready_o), 64'd0);
      check("mid_rst_beat1", 64'(bus_if.m_rvalid_o), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_rvalid", 64'(bus_if.m_rvalid_o), 64'd0);
      check("async_rst_busy", 64'(bus_if.bus_busy_o), 64'd0);
      check("async_rst_req_ready", 64'(bus_if.m_req_ready_o), 64'd0);
      check("async_rst_bus_req_valid", 64'(bus_if.bus_req_valid_o), 64'd0);
      check("async_rst_wready", 64'(bus_if.m_wready_o), 64'd0);
      check("async_rst_state", 64'(dbg_state), 64'(IDLE));
      clear_inputs();
      tick();
      rst_n = 1'b1;
      tick();
      run_txn(1, 1'b0, 2, -1, 0, 1'b0);

      // both ports request single-beat reads back to back
      bus_if.m_req_valid_i   = 2'b11;
      bus_if.m_req_write_i   = 2'b00;
      bus_if.m_req_len_i     = '0;
      bus_if.bus_req_ready_i = 1'b1;
      bus_if.bus_rvalid_i    = 1'b1;
      bus_if.bus_rlast_i     = 1'b1;
      wait_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         got = 0;
         for (int g = 0; g < 10 && !got; g++) begin
            settle();
            if (|bus_if.m_req_ready_o) got = 1;
            else tick();
         end
         check("order_grant_seen", 64'(got), 64'd1);
         exp_g = (wait_cnt == STARVE) ? 2'b01 : 2'b10;
         check($sformatf("order_grant_%0d", k), 64'(bus_if.m_req_ready_o), 64'(exp_g));
         if (exp_g == 2'b01) wait_cnt = 0;
         else if (wait_cnt < STARVE) wait_cnt++;
         tick();
      end
      bus_if.m_req_valid_i = '0;
      tick();
      tick();
      clear_inputs();
      settle();
      check("order_idle", 64'(bus_if.bus_busy_o), 64'd0);
      tick();

      // randomized single-requester transactions
      for (int t = 0; t < 10; t++) begin
         port = $urandom_range(0, 1);
         wr   = ($urandom_range(0, 1) == 1);
         len  = $urandom_range(0, 5);
         fb   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len) : -1;
         run_txn(port, wr, len, fb, $urandom_range(0, 2), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
